// File: rtl/mips_timer_if.sv
// Data-memory port bundle between the CPU MEM stage and the timer.
// The CPU drives the address and store signals; the timer returns read data, select and the interrupt.
interface mips_timer_if;
    logic [31:0] memaddr;
    logic        memwrite;
    logic [31:0] memwritedata;
    logic [31:0] readdata;
    logic        sel;
    logic        irq;

    modport master (
        output memaddr, memwrite, memwritedata,
        input  readdata, sel, irq
    );

    modport slave (
        input  memaddr, memwrite, memwritedata,
        output readdata, sel, irq
    );
endinterface

// File: rtl/mips_timer.sv
// Memory-mapped prescaled 32-bit down-counting timer with one-shot/auto-reload modes.
// Read data is combinational so the CPU's MEM/WB register captures it at the next edge.
module mips_timer #(
    parameter logic [31:0] BASE = 32'hFFFF_0100
) (
    input  logic         clk,
    input  logic         reset,
    mips_timer_if.slave  bus
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    localparam logic [2:0] REG_CTRL  = 3'd0;
    localparam logic [2:0] REG_LOAD  = 3'd1;
    localparam logic [2:0] REG_COUNT = 3'd2;
    localparam logic [2:0] REG_STAT  = 3'd3;
    localparam logic [2:0] REG_PRESC = 3'd4;

    logic [0:0]  r_state;
    logic        r_reload;
    logic        r_irqen;
    logic        r_expired;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic [15:0] r_presc;
    logic [15:0] r_pre;

    logic        w_sel;
    logic        w_wr;
    logic [2:0]  w_idx;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_count;
    logic        w_wr_stat;
    logic        w_wr_presc;
    logic        w_tick;
    logic        w_expire;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_sel      = (bus.memaddr[31:5] == BASE[31:5]);
    assign w_wr       = w_sel & bus.memwrite;
    assign w_idx      = bus.memaddr[4:2];
    assign w_wr_ctrl  = w_wr & (w_idx == REG_CTRL);
    assign w_wr_load  = w_wr & (w_idx == REG_LOAD);
    assign w_wr_count = w_wr & (w_idx == REG_COUNT);
    assign w_wr_stat  = w_wr & (w_idx == REG_STAT);
    assign w_wr_presc = w_wr & (w_idx == REG_PRESC);
    assign w_unused   = &{1'b0, bus.memaddr[1:0]};

    // A tick on a zero count is the expiry event; the old count decides, not any same-edge write.
    assign w_tick   = (r_state == ST_RUN) && (r_pre == r_presc);
    assign w_expire = w_tick && (r_count == 32'd0);

    // Run/idle state and control bits; a CTRL write overrides a same-edge one-shot stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_reload <= 1'b0;
            r_irqen  <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_state  <= bus.memwritedata[0] ? ST_RUN : ST_IDLE;
            r_reload <= bus.memwritedata[1];
            r_irqen  <= bus.memwritedata[2];
        end else if (w_expire && !r_reload) begin
            r_state  <= ST_IDLE;
        end else begin
            r_state  <= r_state;
        end
    end

    // Prescaler: counts 0..PRESC while running, held at 0 when idle or on a CTRL write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= 16'd0;
        end else if (w_wr_ctrl || (r_state == ST_IDLE) || w_tick) begin
            r_pre <= 16'd0;
        end else begin
            r_pre <= r_pre + 16'd1;
        end
    end

    // Count, reload value and prescale divisor; a COUNT write discards a same-edge tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 32'd0;
            r_load  <= 32'd0;
            r_presc <= 16'd0;
        end else begin
            if (w_wr_count) begin
                r_count <= bus.memwritedata;
            end else if (w_tick && (r_count != 32'd0)) begin
                r_count <= r_count - 32'd1;
            end else if (w_expire && r_reload) begin
                r_count <= r_load;
            end else begin
                r_count <= r_count;
            end
            if (w_wr_load) begin
                r_load <= bus.memwritedata;
            end else begin
                r_load <= r_load;
            end
            if (w_wr_presc) begin
                r_presc <= bus.memwritedata[15:0];
            end else begin
                r_presc <= r_presc;
            end
        end
    end

    // Sticky expiry flag; setting beats a same-edge write-1-to-clear so no expiry is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expired <= 1'b0;
        end else if (w_expire) begin
            r_expired <= 1'b1;
        end else if (w_wr_stat && bus.memwritedata[0]) begin
            r_expired <= 1'b0;
        end else begin
            r_expired <= r_expired;
        end
    end

    // Register read mux; unselected or unmapped addresses return zero.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (w_sel) begin
            case (w_idx)
                REG_CTRL:  w_rdata = {29'h0000_0000, r_irqen, r_reload, r_state};
                REG_LOAD:  w_rdata = r_load;
                REG_COUNT: w_rdata = r_count;
                REG_STAT:  w_rdata = {31'h0000_0000, r_expired};
                REG_PRESC: w_rdata = {16'h0000, r_presc};
                default:   w_rdata = 32'h0000_0000;
            endcase
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    assign bus.readdata = w_rdata;
    assign bus.sel      = w_sel;
    assign bus.irq      = r_expired & r_irqen;

endmodule

// File: tb/tb_mips_timer.sv
// Directed self-checking bench for mips_timer with hand-computed expected values.
module tb_mips_timer;

    localparam logic [31:0] BASE    = 32'hFFFF_0100;
    localparam logic [31:0] A_CTRL  = BASE + 32'h00;
    localparam logic [31:0] A_LOAD  = BASE + 32'h04;
    localparam logic [31:0] A_COUNT = BASE + 32'h08;
    localparam logic [31:0] A_STAT  = BASE + 32'h0C;
    localparam logic [31:0] A_PRESC = BASE + 32'h10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] rd;

    mips_timer_if bif ();

    mips_timer #(.BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bif.memaddr      = a;
        bif.memwritedata = d;
        bif.memwrite     = 1'b1;
        @(posedge clk);
        #1;
        bif.memwrite     = 1'b0;
        bif.memaddr      = 32'h0000_0000;
        bif.memwritedata = 32'h0000_0000;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bif.memaddr = a;
        #1;
        d = bif.readdata;
        bif.memaddr = 32'h0000_0000;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bif.memaddr = 32'h0000_0000;
        bif.memwrite = 1'b0;
        bif.memwritedata = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_checks++; if (bif.irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %0b want 0", bif.irq); end
        n_checks++; if (bif.sel !== 1'b0) begin n_fail++; $display("FAIL rst_sel got %0b want 0", bif.sel); end
        n_checks++; if (bif.readdata !== 32'h0) begin n_fail++; $display("FAIL rst_unsel got %h want 0", bif.readdata); end
        bus_read(A_CTRL, rd);  n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl got %h want 0", rd); end
        bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_count got %h want 0", rd); end
        // Start a count, then hit reset mid-cycle and expect everything cleared before the next edge.
        bus_write(A_PRESC, 32'h0);
        bus_write(A_LOAD, 32'h7);
        bus_write(A_COUNT, 32'h5);
        bus_write(A_CTRL, 32'h5);
        step(1);
        bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h4) begin n_fail++; $display("FAIL pre_rst_count got %h want 4", rd); end
        reset = 1'b1;
        bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL async_count got %h want 0", rd); end
        bus_read(A_CTRL, rd);  n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL async_ctrl got %h want 0", rd); end
        bus_read(A_LOAD, rd);  n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL async_load got %h want 0", rd); end
        bus_read(A_STAT, rd);  n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL async_stat got %h want 0", rd); end
        n_checks++; if (bif.irq !== 1'b0) begin n_fail++; $display("FAIL async_irq got %0b want 0", bif.irq); end
        step(1);
        reset = 1'b0;
    endtask

    task automatic test_oneshot;
        bus_write(A_PRESC, 32'h0);
        bus_write(A_LOAD, 32'h0);
        bus_write(A_COUNT, 32'h3);
        bus_write(A_CTRL, 32'h5);
        bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL os_e0 got %h want 3", rd); end
        step(1); bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL os_e1 got %h want 2", rd); end
        step(1); bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL os_e2 got %h want 1", rd); end
        step(1); bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL os_e3 got %h want 0", rd); end
        n_checks++; if (bif.irq !== 1'b0) begin n_fail++; $display("FAIL os_irq_e3 got %0b want 0", bif.irq); end
        step(1);
        n_checks++; if (bif.irq !== 1'b1) begin n_fail++; $display("FAIL os_irq_e4 got %0b want 1", bif.irq); end
        bus_read(A_CTRL, rd);  n_checks++; if (rd !== 32'h4) begin n_fail++; $display("FAIL os_ctrl got %h want 4", rd); end
        bus_read(A_STAT, rd);  n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL os_stat got %h want 1", rd); end
        step(1); bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL os_hold got %h want 0", rd); end
        bus_write(A_STAT, 32'h0);
        bus_read(A_STAT, rd);  n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL os_w0 got %h want 1", rd); end
        bus_write(A_STAT, 32'h1);
        bus_read(A_STAT, rd);  n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL os_w1c got %h want 0", rd); end
        n_checks++; if (bif.irq !== 1'b0) begin n_fail++; $display("FAIL os_irq_clr got %0b want 0", bif.irq); end
    endtask

    task automatic test_autoreload;
        bus_write(A_CTRL, 32'h0);
        bus_write(A_LOAD, 32'h2);
        bus_write(A_COUNT, 32'h2);
        bus_write(A_PRESC, 32'h1);
        bus_write(A_CTRL, 32'h3);
        step(5); bus_read(A_STAT, rd); n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ar_e5 got %h want 0", rd); end
        step(1); bus_read(A_STAT, rd); n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL ar_e6 got %h want 1", rd); end
        bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL ar_reload6 got %h want 2", rd); end
        bus_write(A_STAT, 32'h1);
        bus_read(A_STAT, rd); n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ar_clr got %h want 0", rd); end
        step(4); bus_read(A_STAT, rd); n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ar_e11 got %h want 0", rd); end
        step(1); bus_read(A_STAT, rd); n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL ar_e12 got %h want 1", rd); end
        bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL ar_reload12 got %h want 2", rd); end
        bus_read(A_CTRL, rd);  n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL ar_ctrl got %h want 3", rd); end
    endtask

    task automatic test_simultaneous;
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STAT, 32'h1);
        bus_write(A_LOAD, 32'h2);
        bus_write(A_COUNT, 32'h2);
        bus_write(A_PRESC, 32'h1);
        bus_write(A_CTRL, 32'h3);
        // Expiry on E6: clearing on that same edge must not lose it.
        step(5);
        bus_write(A_STAT, 32'h1);
        bus_read(A_STAT, rd); n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL sim_clr_exp got %h want 1", rd); end
        // Tick on E8: the written count wins.
        step(1);
        bus_write(A_COUNT, 32'h9);
        bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h9) begin n_fail++; $display("FAIL sim_cnt_e8 got %h want 9", rd); end
        step(1); bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h9) begin n_fail++; $display("FAIL sim_cnt_e9 got %h want 9", rd); end
        step(1); bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL sim_cnt_e10 got %h want 8", rd); end
        // CTRL write on a one-shot expiry edge keeps the written enable.
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STAT, 32'h1);
        bus_write(A_PRESC, 32'h0);
        bus_write(A_COUNT, 32'h0);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_CTRL, rd); n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL sim_ctrl_en got %h want 1", rd); end
        bus_read(A_STAT, rd); n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL sim_ctrl_exp got %h want 1", rd); end
        // LOAD write on a reload edge: count takes the old LOAD.
        bus_write(A_CTRL, 32'h0);
        bus_write(A_COUNT, 32'h0);
        bus_write(A_LOAD, 32'h5);
        bus_write(A_CTRL, 32'h3);
        bus_write(A_LOAD, 32'h7);
        bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL sim_load_cnt got %h want 5", rd); end
        bus_read(A_LOAD, rd);  n_checks++; if (rd !== 32'h7) begin n_fail++; $display("FAIL sim_load_new got %h want 7", rd); end
        // Maximum count decrements normally.
        bus_write(A_CTRL, 32'h0);
        bus_write(A_COUNT, 32'hFFFF_FFFF);
        bus_write(A_CTRL, 32'h1);
        step(1); bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sim_max got %h want fffffffe", rd); end
    endtask

    task automatic test_decode;
        bus_write(A_CTRL, 32'h4);
        bus_write(A_STAT, 32'h1);
        bus_write(A_LOAD, 32'h0000_1111);
        bus_write(A_COUNT, 32'h0000_2222);
        bus_write(A_PRESC, 32'h0000_0003);
        bif.memaddr = BASE + 32'h1C; #1;
        n_checks++; if (bif.sel !== 1'b1) begin n_fail++; $display("FAIL dec_sel1c got %0b want 1", bif.sel); end
        n_checks++; if (bif.readdata !== 32'h0) begin n_fail++; $display("FAIL dec_rd1c got %h want 0", bif.readdata); end
        bif.memaddr = BASE + 32'h20; #1;
        n_checks++; if (bif.sel !== 1'b0) begin n_fail++; $display("FAIL dec_sel20 got %0b want 0", bif.sel); end
        n_checks++; if (bif.readdata !== 32'h0) begin n_fail++; $display("FAIL dec_rd20 got %h want 0", bif.readdata); end
        bus_write(BASE + 32'h20, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h28, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h14, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h1C, 32'hFFFF_FFFF);
        bus_read(A_CTRL, rd);  n_checks++; if (rd !== 32'h4) begin n_fail++; $display("FAIL dec_ctrl got %h want 4", rd); end
        bus_read(A_LOAD, rd);  n_checks++; if (rd !== 32'h1111) begin n_fail++; $display("FAIL dec_load got %h want 1111", rd); end
        bus_read(A_COUNT, rd); n_checks++; if (rd !== 32'h2222) begin n_fail++; $display("FAIL dec_count got %h want 2222", rd); end
        bus_read(A_PRESC, rd); n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL dec_presc got %h want 3", rd); end
        bus_write(A_PRESC, 32'hABCD_1234);
        bus_read(A_PRESC, rd); n_checks++; if (rd !== 32'h0000_1234) begin n_fail++; $display("FAIL dec_presc_hi got %h want 00001234", rd); end
        bus_read(A_COUNT + 32'h3, rd); n_checks++; if (rd !== 32'h2222) begin n_fail++; $display("FAIL dec_lowbits got %h want 2222", rd); end
    endtask

    initial begin
        test_reset;
        test_oneshot;
        test_autoreload;
        test_simultaneous;
        test_decode;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
